// File: rtl/systolic_result_drain_pkg.sv
// Shared types and helpers for the systolic result drain.
// Latency: none (declarations only).
// Backpressure: not applicable.
package systolic_result_drain_pkg;

  // Drain job sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int SHIFT_WIDTH = 5;
  localparam int ROWS_WIDTH  = 16;

  // Largest value representable in a signed lane of out_width bits
  function automatic longint sat_max(input int out_width);
    return (longint'(1) << (out_width - 1)) - 1;
  endfunction

  // Smallest value representable in a signed lane of out_width bits
  function automatic longint sat_min(input int out_width);
    return -(longint'(1) << (out_width - 1));
  endfunction

endpackage

// File: rtl/systolic_result_drain_quant_lane.sv
// One accumulator lane: round-half-up, arithmetic right shift, optional ReLU, saturate.
// Latency: purely combinational.
// Backpressure: none; follows its input.
module result_quant_lane
  import systolic_result_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0]   lane_in,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu,
  output logic [OUT_WIDTH-1:0]   lane_out
);

  // One guard bit so adding the rounding bias to the largest lane cannot wrap
  localparam int XW = ACC_WIDTH + 1;
  localparam logic signed [XW-1:0] HI = XW'(sat_max(OUT_WIDTH));
  localparam logic signed [XW-1:0] LO = XW'(sat_min(OUT_WIDTH));

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] bias;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] r;

  // Round, shift, clamp negatives when ReLU is on, then saturate to the output range
  always_comb begin
    x_ext = signed'({lane_in[ACC_WIDTH-1], lane_in});
    bias  = '0;
    if (shift != '0) begin
      bias = XW'(1) << (shift - SHIFT_WIDTH'(1));
    end
    sum = x_ext + bias;
    r   = sum >>> shift;
    if (relu && r[XW-1]) begin
      r = '0;
    end
    if (r > HI) begin
      r = HI;
    end else if (r < LO) begin
      r = LO;
    end
    lane_out = r[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains systolic result vectors through a small FIFO, quantizes each lane and writes to a buffer.
// Latency: vector accepted at edge N appears on wr_* after edge N+1; 1 vector/cycle sustained.
// Backpressure: wr_ready low holds wr_*; FIFO fills, then in_ready drops.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ROWS_WIDTH-1:0]            cfg_num_rows,
  input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
  input  logic [SHIFT_WIDTH-1:0]           cfg_shift,
  input  logic                             cfg_relu,
  output logic                             busy,
  output logic                             done,
  input  logic                             in_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  in_data,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0]  wr_data,
  input  logic                             wr_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IN_W  = ARRAY_SIZE * ACC_WIDTH;
  localparam int OUT_W = ARRAY_SIZE * OUT_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  state_t state;
  state_t state_nxt;

  // Job configuration captured at start
  logic [ROWS_WIDTH-1:0]  rows_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;

  // Job progress: vectors accepted, writes accepted, vectors loaded into the output register
  logic [ROWS_WIDTH-1:0]  acc_cnt;
  logic [ROWS_WIDTH-1:0]  wr_cnt;
  logic [ADDR_WIDTH-1:0]  ld_idx;

  logic [IN_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W:0]         fifo_cnt;
  logic [IN_W-1:0]        fifo_head;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   accept;
  logic                   last_write;
  logic                   start_job;

  logic                   out_vld;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic [OUT_W-1:0]       out_data;
  logic [OUT_W-1:0]       quant_data;

  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = in_valid && in_ready;
  assign accept     = out_vld && wr_ready;
  // Refill the output register whenever it is empty or its content leaves this cycle
  assign pop        = !fifo_empty && (!out_vld || accept);
  assign last_write = accept && (wr_cnt == rows_q - ROWS_WIDTH'(1));
  assign start_job  = (state == ST_IDLE) && start;
  assign fifo_head  = fifo_mem[rd_ptr];

  assign wr_en   = out_vld;
  assign wr_addr = out_addr;
  assign wr_data = out_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a zero-row job goes straight to FINISH; DRAIN ends on the last accepted write
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (cfg_num_rows == '0) ? ST_FINISH : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_write) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; input is accepted only while draining and rows remain
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state)
      ST_DRAIN: begin
        busy     = 1'b1;
        in_ready = !fifo_full && (acc_cnt < rows_q);
      end
      ST_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch configuration and clear counters at job start; count progress otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      base_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      ld_idx  <= '0;
    end else if (start_job) begin
      rows_q  <= cfg_num_rows;
      base_q  <= cfg_base_addr;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      ld_idx  <= '0;
    end else begin
      if (push) acc_cnt <= acc_cnt + ROWS_WIDTH'(1);
      if (accept) wr_cnt <= wr_cnt + ROWS_WIDTH'(1);
      if (pop) ld_idx <= ld_idx + ADDR_WIDTH'(1);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  // Output register: load the quantized head, hold while the buffer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (pop) begin
      out_vld  <= 1'b1;
      out_addr <= base_q + ld_idx;
      out_data <= quant_data;
    end else if (accept) begin
      out_vld  <= 1'b0;
    end
  end

  // One quantizer per lane on the FIFO head
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    result_quant_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
    ) u_lane (
      .lane_in  (fifo_head[g*ACC_WIDTH +: ACC_WIDTH]),
      .shift    (shift_q),
      .relu     (relu_q),
      .lane_out (quant_data[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed and randomized checks of the result drain: quantization table, latency,
// backpressure, zero-row jobs, mid-job reset and a reference-model random run.
module tb_systolic_result_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  cfg_num_rows;
  logic [15:0]  cfg_base_addr;
  logic [4:0]   cfg_shift;
  logic         cfg_relu;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         wr_en;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_ready;

  systolic_result_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_num_rows  (cfg_num_rows),
    .cfg_base_addr (cfg_base_addr),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [15:0] got_addr [$];
  logic [31:0] got_data [$];

  // Writes are captured on the falling edge, where inputs and outputs are settled
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en && wr_ready) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [127:0] mk4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] mk8(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reference quantizer using 64-bit arithmetic
  function automatic logic [7:0] qmodel(input logic [31:0] x, input int s, input logic rl);
    longint v;
    v = longint'($signed(x));
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [31:0] qvec(input logic [127:0] d, input int s, input logic rl);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = qmodel(d[i*32 +: 32], s, rl);
    return r;
  endfunction

  function automatic logic [127:0] bpv(input int k);
    return mk4(k + 1, -(k + 1), 3 * k, -100);
  endfunction

  function automatic logic [31:0] bpe(input int k);
    return mk8(k + 1, -(k + 1), 3 * k, -100);
  endfunction

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'(int'($urandom_range(0, 4095)) - 2048);
      2:       return 32'(int'($urandom_range(0, 1 << 20)) - (1 << 19));
      default: return 32'(int'($urandom_range(0, 255)) - 128);
    endcase
  endfunction

  // Entered and left just after a rising edge
  task automatic start_job(input logic [15:0] rows, input logic [15:0] base,
                           input logic [4:0] sh, input logic rl);
    start = 1'b1;
    cfg_num_rows = rows;
    cfg_base_addr = base;
    cfg_shift = sh;
    cfg_relu = rl;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_vec(input logic [127:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) timeout_fail("push_vec");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 3000) begin
      t++;
      @(negedge clk);
    end
    chk(name, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [127:0] lanes;
    logic [4:0]   shift;
    logic         relu;
    logic [31:0]  exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic sampled;
    int acc;
    int idx;
    int t;
    int sh;
    logic rl;
    logic [15:0] base;
    logic [15:0] exp_a [$];
    logic [31:0] exp_d [$];

    tbl[0] = '{mk4(40, -40, 8, 7),   5'd4,  1'b0, mk8(3, -2, 1, 0)};
    tbl[1] = '{mk4(0, 16, -8, -9),   5'd4,  1'b0, mk8(0, 1, 0, -1)};
    tbl[2] = '{mk4(10000, -10000, 127, -128), 5'd0, 1'b0, mk8(127, -128, 127, -128)};
    tbl[3] = '{mk4(10000, -10000, 127, -128), 5'd0, 1'b1, mk8(127, 0, 127, 0)};
    tbl[4] = '{mk4(3, -3, 1, -1),    5'd1,  1'b0, mk8(2, -1, 1, 0)};
    tbl[5] = '{mk4(-40, 2040, 2032, 255), 5'd4, 1'b1, mk8(0, 127, 127, 16)};
    tbl[6] = '{mk4(32'h7FFF_FFFF, int'(32'h8000_0000), 0, 0), 5'd31, 1'b0, mk8(1, -1, 0, 0)};
    tbl[7] = '{mk4(-4, -5, 1020, -1028), 5'd3, 1'b0, mk8(0, -1, 127, -128)};

    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_num_rows = '0;
    cfg_base_addr = '0;
    cfg_shift = '0;
    cfg_relu = 1'b0;
    wr_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", 64'(wr_data), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Quantization table, one single-row job per entry
    for (int i = 0; i < 8; i++) begin
      got_addr.delete(); got_data.delete(); done_cnt = 0;
      start_job(16'd1, 16'h0200 + 16'(i), tbl[i].shift, tbl[i].relu);
      push_vec(tbl[i].lanes);
      wait_idle($sformatf("tbl%0d_idle", i));
      chk($sformatf("tbl%0d_nwr", i), 64'(got_data.size()), 1);
      if (got_data.size() > 0) begin
        chk($sformatf("tbl%0d_data", i), 64'(got_data[0]), 64'(tbl[i].exp));
        chk($sformatf("tbl%0d_addr", i), 64'(got_addr[0]), 64'(16'h0200 + 16'(i)));
      end
      chk($sformatf("tbl%0d_done", i), 64'(done_cnt), 1);
    end

    // Basic two-row drain with latency and throughput checks
    got_addr.delete(); got_data.delete(); done_cnt = 0;
    start_job(16'd2, 16'h0100, 5'd4, 1'b0);
    in_valid = 1'b1;
    in_data = mk4(40, -40, 8, 7);
    @(negedge clk); chk("b_rdy0", 64'(in_ready), 1);
    @(posedge clk); #1;
    in_data = mk4(0, 16, -8, -9);
    @(negedge clk);
    chk("b_lat_early", 64'(wr_en), 0);
    chk("b_rdy1", 64'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_lat_wr_en", 64'(wr_en), 1);
    chk("b_addr0", 64'(wr_addr), 64'h100);
    chk("b_rdy_cap", 64'(in_ready), 0);
    @(negedge clk);
    chk("b_thru_wr_en", 64'(wr_en), 1);
    chk("b_thru_addr", 64'(wr_addr), 64'h101);
    wait_idle("b_idle");
    chk("b_nwr", 64'(got_data.size()), 2);
    if (got_data.size() == 2) begin
      chk("b_d0", 64'(got_data[0]), 64'(mk8(3, -2, 1, 0)));
      chk("b_a0", 64'(got_addr[0]), 64'h100);
      chk("b_d1", 64'(got_data[1]), 64'(mk8(0, 1, 0, -1)));
      chk("b_a1", 64'(got_addr[1]), 64'h101);
    end
    chk("b_done", 64'(done_cnt), 1);

    // Backpressure: 10 stalled cycles, plus a start pulse that must be ignored
    got_addr.delete(); got_data.delete(); done_cnt = 0;
    wr_ready = 1'b0;
    start_job(16'd8, 16'h0040, 5'd0, 1'b0);
    acc = 0;
    in_valid = 1'b1;
    in_data = bpv(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sampled = in_ready;
      if (c == 3) begin
        chk("bp_wr_en_c3", 64'(wr_en), 1);
        chk("bp_addr_c3", 64'(wr_addr), 64'h40);
        chk("bp_data_c3", 64'(wr_data), 64'(bpe(0)));
      end
      if (c == 9) begin
        chk("bp_hold_wr_en", 64'(wr_en), 1);
        chk("bp_hold_addr", 64'(wr_addr), 64'h40);
        chk("bp_hold_data", 64'(wr_data), 64'(bpe(0)));
        chk("bp_rdy_low", 64'(in_ready), 0);
      end
      @(posedge clk); #1;
      start = (c == 2);
      if (c == 2) begin
        cfg_num_rows = 16'd1;
        cfg_base_addr = 16'h0999;
      end
      if (sampled) begin
        acc++;
        in_data = bpv(acc);
      end
    end
    chk("bp_accepted", 64'(acc), 64'(5));
    wr_ready = 1'b1;
    t = 0;
    while (acc < 8 && t < 200) begin
      t++;
      @(negedge clk);
      sampled = in_ready;
      @(posedge clk); #1;
      if (sampled) begin
        acc++;
        if (acc < 8) in_data = bpv(acc);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (acc < 8) timeout_fail("bp_push");
    wait_idle("bp_idle");
    chk("bp_nwr", 64'(got_data.size()), 8);
    if (got_data.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("bp_a%0d", k), 64'(got_addr[k]), 64'(16'h40 + 16'(k)));
        chk($sformatf("bp_d%0d", k), 64'(got_data[k]), 64'(bpe(k)));
      end
    end
    chk("bp_done", 64'(done_cnt), 1);

    // Zero-row job
    got_addr.delete(); got_data.delete(); done_cnt = 0;
    in_valid = 1'b1;
    in_data = mk4(1, 2, 3, 4);
    @(negedge clk); chk("z_idle_rdy", 64'(in_ready), 0);
    @(posedge clk); #1;
    start_job(16'd0, 16'h0055, 5'd0, 1'b0);
    @(negedge clk);
    chk("z_done", 64'(done), 1);
    chk("z_busy", 64'(busy), 1);
    chk("z_rdy", 64'(in_ready), 0);
    @(negedge clk);
    chk("z_done_off", 64'(done), 0);
    chk("z_busy_off", 64'(busy), 0);
    chk("z_rdy_after", 64'(in_ready), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("z_nwr", 64'(got_data.size()), 0);
    chk("z_done_cnt", 64'(done_cnt), 1);

    // Reset in the middle of a stalled job
    got_addr.delete(); got_data.delete();
    wr_ready = 1'b0;
    start_job(16'd6, 16'h0300, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) push_vec(mk4(100 + k, 5, 6, 7));
    @(negedge clk);
    chk("r_pre_wr_en", 64'(wr_en), 1);
    chk("r_pre_addr", 64'(wr_addr), 64'h300);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy", 64'(busy), 0);
    chk("r_done", 64'(done), 0);
    chk("r_in_ready", 64'(in_ready), 0);
    chk("r_wr_en", 64'(wr_en), 0);
    chk("r_wr_addr", 64'(wr_addr), 0);
    chk("r_wr_data", 64'(wr_data), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    got_addr.delete(); got_data.delete(); done_cnt = 0;
    wr_ready = 1'b1;
    @(posedge clk); #1;
    start_job(16'd2, 16'h0380, 5'd2, 1'b0);
    push_vec(mk4(8, -8, 100, 3));
    push_vec(mk4(-1, 1, -2, 2));
    wait_idle("r_idle");
    chk("r_nwr", 64'(got_data.size()), 2);
    if (got_data.size() == 2) begin
      chk("r_a0", 64'(got_addr[0]), 64'h380);
      chk("r_d0", 64'(got_data[0]), 64'(mk8(2, -2, 25, 1)));
      chk("r_a1", 64'(got_addr[1]), 64'h381);
      chk("r_d1", 64'(got_data[1]), 64'(mk8(0, 0, 0, 1)));
    end
    chk("r_done_cnt", 64'(done_cnt), 1);

    // Random: 5 jobs x 40 vectors against the reference quantizer
    for (int j = 0; j < 5; j++) begin
      got_addr.delete(); got_data.delete(); done_cnt = 0;
      exp_a.delete(); exp_d.delete();
      sh = int'($urandom_range(0, 31));
      rl = 1'($urandom_range(0, 1));
      base = (j == 0) ? 16'hFFEC : 16'($urandom());
      start_job(16'd40, base, 5'(sh), rl);
      idx = 0;
      t = 0;
      in_valid = 1'b0;
      while (idx < 40 && t < 3000) begin
        t++;
        @(negedge clk);
        sampled = in_valid && in_ready;
        @(posedge clk); #1;
        wr_ready = ($urandom_range(0, 3) != 0);
        if (sampled) begin
          exp_d.push_back(qvec(in_data, sh, rl));
          exp_a.push_back(16'(base + 16'(idx)));
          idx++;
          in_valid = 1'b0;
        end
        if (!in_valid && idx < 40 && $urandom_range(0, 2) != 0) begin
          in_data = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
          in_valid = 1'b1;
        end
      end
      in_valid = 1'b0;
      if (idx < 40) timeout_fail($sformatf("rnd%0d_push", j));
      wr_ready = 1'b1;
      wait_idle($sformatf("rnd%0d_idle", j));
      chk($sformatf("rnd%0d_nwr", j), 64'(got_data.size()), 64'(exp_d.size()));
      if (got_data.size() == exp_d.size()) begin
        for (int k = 0; k < exp_d.size(); k++) begin
          chk($sformatf("rnd%0d_a%0d", j, k), 64'(got_addr[k]), 64'(exp_a[k]));
          chk($sformatf("rnd%0d_d%0d", j, k), 64'(got_data[k]), 64'(exp_d[k]));
        end
      end
      chk($sformatf("rnd%0d_done", j), 64'(done_cnt), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 Parameters SHALL be: ARRAY_SIZE, default 4, lanes per result vector; ACC_WIDTH, default 32, signed accumulator lane width; OUT_WIDTH, default 8, signed output lane width; FIFO_DEPTH, default 4, result vectors buffered (power of 2); ADDR_WIDTH, default 16, write address width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  begin drain job.
- cfg_num_rows  in  16  vectors to drain.
- cfg_base_addr  in  ADDR_WIDTH  first write address.
- cfg_shift  in  5  right-shift amount.
- cfg_relu  in  1  clamp negatives to 0.
- busy  out  1  job active.
- done  out  1  one-cycle completion pulse.
- in_valid  in  1  result vector valid; from systolic result_valid.
- in_data  in  ARRAY_SIZE*ACC_WIDTH  result vector; lane i at [i*ACC_WIDTH +: ACC_WIDTH].
- in_ready  out  1  to systolic result_ready.
- wr_en  out  1  buffer write request.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  ARRAY_SIZE*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH].
- wr_ready  in  1  buffer accepts write.
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, DRAIN, FINISH.
REQ-005 IDLE + start=1: latch all cfg_* and clear row counters. Go to DRAIN, or to FINISH if cfg_num_rows==0.
REQ-006 start SHALL be ignored outside IDLE.
REQ-007 in_ready SHALL be 1 only in DRAIN while FIFO is not full and accepted count < latched cfg_num_rows. in_valid&&in_ready SHALL push in_data into the FIFO.
REQ-008 A push while full SHALL never occur. Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-009 Output register loading:
- Occurs when the FIFO is non-empty and the output register is empty or being accepted (wr_en&&wr_ready).
- The head vector is popped, quantized, and loaded into the output register.
- wr_en=1 while the register is full.
REQ-010 wr_en, wr_addr, wr_data SHALL be held stable while wr_en=1 and wr_ready=0.
REQ-011 Per-lane quantization:
- s = cfg_shift; x = signed lane.
- r = (x + (s>0 ? 1<<(s-1) : 0)) >>> s, computed in ACC_WIDTH+1 bits (no overflow).
- If cfg_relu and r<0, r = 0.
- Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-012 wr_addr SHALL be cfg_base_addr + write index (0-based, wraps modulo 2^ADDR_WIDTH).
REQ-013 Latency: vector pushed at edge N, FIFO empty, output register empty → wr_en=1 after edge N+1. Sustained throughput SHALL be 1 vector/cycle with wr_ready=1.
REQ-014 When the cfg_num_rows-th write is accepted, the FSM SHALL go to FINISH. In FINISH, done=1 for one cycle, then IDLE.
REQ-015 busy SHALL be 1 in DRAIN and FINISH, 0 in IDLE.
REQ-016 in_valid outside DRAIN SHALL not be accepted (in_ready=0).

Reset
REQ-017 rst_n=0 at any time, including mid-job, SHALL immediately:
- force state IDLE;
- empty the FIFO;
- clear the output register and counters;
- drive busy=0, done=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
Buffered data SHALL be discarded.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and the saturation bound constants derived from OUT_WIDTH.
REQ-019 One sub-module, result_quant_lane (round, shift, ReLU, saturate; combinational), SHALL be instantiated ARRAY_SIZE times by generate.

Verification
REQ-020 Basic drain: shift=4, relu=0, base=0x100, rows=2.
- Stimulus: vectors {40,-40,8,7}, {0,16,-8,-9}.
- Response: writes 0x100={3,-2,1,0}, 0x101={0,1,0,-1}; done pulse once; busy falls.
REQ-021 Saturation: shift=0; lanes {10000,-10000,127,-128}.
- relu=0 → {127,-128,127,-128}.
- relu=1 → {127,0,127,0}.
REQ-022 Backpressure: rows=8; wr_ready=0 for 10 cycles.
- in_ready drops after FIFO_DEPTH+1 vectors accepted.
- wr_* held stable.
- All 8 writes in order after release.
REQ-023 Zero rows: start with rows=0 → no wr_en; done pulse; in_ready stays 0.
REQ-024 Reset mid-job: assert rst_n=0 after 3 of 6 vectors, with wr_ready=0.
- All outputs immediately 0.
- A new job after release writes only its own data from its own base.
REQ-025 Random: 200 vectors, random in_valid/wr_ready, random shift/relu; outputs match a reference model bit-exactly, in order, with consecutive addresses.
